tcam_search_ctrl: RTL

TCAM_SEARCH_CTRL -- requirements
Module: tcam_search_ctrl

---
 rtl/tcam_search_ctrl_pkg.sv | 17 +
 rtl/tcam_search_ctrl_prio_enc.sv | 32 +++
 rtl/tcam_search_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tcam_search_ctrl_pkg.sv
// Shared definitions for the TCAM search controller: request opcodes and FSM states.
package tcam_search_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_SEARCH     = 2'd0,
      OP_WRITE      = 2'd1,
      OP_INVALIDATE = 2'd2
   } tcam_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      SEARCH = 2'd2,
      RESULT = 2'd3
   } tcam_state_e;

endpackage

// File: rtl/tcam_search_ctrl_prio_enc.sv
// Lowest-index priority encoder with a multi-hit flag over the qualified match vector.
module tcam_prio_enc #(
   parameter int CAM_DEPTH = 8,
   parameter int ADDR_W    = 3
) (
   input  logic [CAM_DEPTH-1:0] vec_i,
   output logic                 hit_o,
   output logic [ADDR_W-1:0]    addr_o,
   output logic                 multi_o
);

   // Scan high to low so the lowest set index wins; a second set bit raises multi.
   always_comb begin
      hit_o   = 1'b0;
      addr_o  = '0;
      multi_o = 1'b0;
      for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            addr_o = ADDR_W'(i);
         end
      end
      for (int i = 0; i < CAM_DEPTH; i++) begin
         if (vec_i[i]) begin
            if (hit_o) begin
               multi_o = 1'b1;
            end
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tcam_search_ctrl.sv
// TCAM search controller: accepts search/write/invalidate requests, drives the row
// array's shared word/mask and per-row write enables, and returns prioritised results.
module tcam_search_ctrl
   import tcam_search_ctrl_pkg::*;
#(
   parameter int CAM_WIDTH = 8,
   parameter int CAM_DEPTH = 8,
   parameter int ADDR_W    = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [1:0]           req_op_i,
   input  logic [CAM_WIDTH-1:0] req_word_i,
   input  logic [CAM_WIDTH-1:0] req_mask_i,
   input  logic [ADDR_W-1:0]    req_addr_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic                 rsp_hit_o,
   output logic [ADDR_W-1:0]    rsp_addr_o,
   output logic                 rsp_multi_o,
   output logic                 cam_rst_o,
   output logic [CAM_DEPTH-1:0] cam_we_o,
   output logic [CAM_WIDTH-1:0] cam_search_word_o,
   output logic [CAM_WIDTH-1:0] cam_dont_care_mask_o,
   input  logic [CAM_DEPTH-1:0] cam_match_i
);

   tcam_state_e          state_q;
   logic [CAM_WIDTH-1:0] word_q;
   logic [CAM_WIDTH-1:0] mask_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [1:0]           op_q;
   logic [CAM_DEPTH-1:0] row_valid_q;
   logic [CAM_DEPTH-1:0] cam_we_q;
   logic                 rsp_valid_q;
   logic                 rsp_hit_q;
   logic [ADDR_W-1:0]    rsp_addr_q;
   logic                 rsp_multi_q;

   logic                 accept;
   logic [CAM_DEPTH-1:0] row_sel_d;
   logic [CAM_DEPTH-1:0] qual_d;
   logic                 enc_hit;
   logic [ADDR_W-1:0]    enc_addr;
   logic                 enc_multi;

   assign req_ready_o          = (state_q == IDLE) && !rst_i;
   assign accept               = req_valid_i && req_ready_o;
   assign cam_rst_o            = rst_i;
   assign cam_we_o             = cam_we_q;
   assign cam_search_word_o    = word_q;
   assign cam_dont_care_mask_o = mask_q;
   assign rsp_valid_o          = rsp_valid_q;
   assign rsp_hit_o            = rsp_hit_q;
   assign rsp_addr_o           = rsp_addr_q;
   assign rsp_multi_o          = rsp_multi_q;

   // One-hot row decode of the request address; addresses beyond the array select nothing.
   always_comb begin
      row_sel_d = '0;
      for (int i = 0; i < CAM_DEPTH; i++) begin
         row_sel_d[i] = (req_addr_i == ADDR_W'(i));
      end
   end

   // Only rows holding valid data may contribute to a search result.
   always_comb begin
      qual_d = cam_match_i & row_valid_q;
   end

   tcam_prio_enc #(
      .CAM_DEPTH (CAM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_prio_enc (
      .vec_i   (qual_d),
      .hit_o   (enc_hit),
      .addr_o  (enc_addr),
      .multi_o (enc_multi)
   );

   // Control FSM with registered write enables, row-valid bits and response fields.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         word_q      <= '0;
         mask_q      <= '0;
         addr_q      <= '0;
         op_q        <= '0;
         row_valid_q <= '0;
         cam_we_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_multi_q <= 1'b0;
      end else begin
         cam_we_q <= '0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  word_q <= req_word_i;
                  mask_q <= req_mask_i;
                  addr_q <= req_addr_i;
                  op_q   <= req_op_i;
                  case (req_op_i)
                     OP_WRITE: begin
                        cam_we_q <= row_sel_d;
                        state_q  <= WRITE;
                     end
                     OP_SEARCH: begin
                        state_q <= SEARCH;
                     end
                     OP_INVALIDATE: begin
                        row_valid_q <= row_valid_q & ~row_sel_d;
                     end
                     default: begin
                     end
                  endcase
               end
            end
            WRITE: begin
               if (op_q == OP_WRITE) begin
                  row_valid_q <= row_valid_q | cam_we_q;
               end
               state_q <= IDLE;
            end
            SEARCH: begin
               rsp_valid_q <= 1'b1;
               rsp_hit_q   <= enc_hit;
               rsp_addr_q  <= enc_addr;
               rsp_multi_q <= enc_multi;
               state_q     <= RESULT;
            end
            RESULT: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
